// File: rtl/srp16_boot_loader.sv
// Framed byte-stream loader: writes payload into program memory, releases the CPU on a verified checksum.
// Latency: one write per accepted payload byte, registered one cycle later; done/cpu_hold register on the CSUM edge.
// Backpressure: rx_ready is low only in DONE; memory is never allowed to stall the loader.
module srp16_boot_loader #(
    parameter logic [7:0]  SYNC_BYTE      = 8'hA5,
    parameter int unsigned TIMEOUT_CYCLES = 65535
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    output logic [15:0] mem_addr,
    output logic [7:0]  mem_wdata,
    output logic        mem_we,
    output logic        cpu_hold,
    output logic        done,
    output logic        error,
    output logic [1:0]  error_code
);
    typedef enum logic [3:0] {
        S_IDLE, S_ADDR_H, S_ADDR_L, S_LEN_H, S_LEN_L, S_DATA, S_CSUM, S_DONE, S_ERROR
    } state_t;

    localparam logic [19:0] TO_LAST = 20'(TIMEOUT_CYCLES - 1);

    state_t      state, state_nxt;
    logic [15:0] addr;
    logic [15:0] remaining;
    logic [7:0]  len_h;
    logic [7:0]  sum;
    logic [7:0]  sum_fin;
    logic [15:0] len_full;
    logic [19:0] idle_cnt;
    logic        accept;
    logic        in_frame;
    logic        timeout;
    logic        is_sync;

    assign rx_ready = (state != S_DONE);
    assign done     = (state == S_DONE);
    assign cpu_hold = (state != S_DONE);
    assign error    = (state == S_ERROR);
    assign accept   = rx_valid && rx_ready;
    assign is_sync  = (rx_data == SYNC_BYTE);
    assign sum_fin  = sum + rx_data;
    assign len_full = {len_h, rx_data};
    assign in_frame = (state == S_ADDR_H) || (state == S_ADDR_L) || (state == S_LEN_H) ||
                      (state == S_LEN_L)  || (state == S_DATA)   || (state == S_CSUM);
    // An accepted byte on the expiry edge wins over the timeout.
    assign timeout  = in_frame && !accept && (idle_cnt == TO_LAST);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (timeout) begin
            state_nxt = S_ERROR;
        end else if (accept) begin
            case (state)
                S_IDLE, S_ERROR: if (is_sync) state_nxt = S_ADDR_H;
                S_ADDR_H: state_nxt = S_ADDR_L;
                S_ADDR_L: state_nxt = S_LEN_H;
                S_LEN_H:  state_nxt = S_LEN_L;
                S_LEN_L:  state_nxt = (len_full == 16'h0000) ? S_CSUM : S_DATA;
                S_DATA:   state_nxt = (remaining == 16'h0001) ? S_CSUM : S_DATA;
                S_CSUM:   state_nxt = (sum_fin == 8'h00) ? S_DONE : S_ERROR;
                default:  state_nxt = state;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            addr       <= 16'h0000;
            remaining  <= 16'h0000;
            len_h      <= 8'h00;
            sum        <= 8'h00;
            idle_cnt   <= 20'd0;
            mem_addr   <= 16'h0000;
            mem_wdata  <= 8'h00;
            mem_we     <= 1'b0;
            error_code <= 2'b00;
        end else begin
            mem_we <= 1'b0;
            if (!in_frame || accept) idle_cnt <= 20'd0;
            else                     idle_cnt <= idle_cnt + 20'd1;

            if (timeout) begin
                error_code <= 2'b10;
            end else if (accept) begin
                case (state)
                    S_IDLE, S_ERROR: begin
                        if (is_sync) begin
                            sum        <= 8'h00;
                            error_code <= 2'b00;
                        end
                    end
                    S_ADDR_H: addr[15:8] <= rx_data;
                    S_ADDR_L: addr[7:0]  <= rx_data;
                    S_LEN_H:  len_h      <= rx_data;
                    S_LEN_L:  remaining  <= len_full;
                    S_DATA: begin
                        mem_we    <= 1'b1;
                        mem_addr  <= addr;
                        mem_wdata <= rx_data;
                        addr      <= addr + 16'h0001;
                        remaining <= remaining - 16'h0001;
                        sum       <= sum_fin;
                    end
                    S_CSUM: if (sum_fin != 8'h00) error_code <= 2'b01;
                    default: ;
                endcase
            end
        end
    end
endmodule
